hazard_scoreboard: RTL and testbench

- Parametrised hazard/forwarding controller for the in-order MIPS pipeline; successor of the fixed EX/MEM-only decode-stage hazard logic.
- Tracks in-flight register writes in a shift-register scoreboard PIPE_DEPTH stages deep, with a configurable load latency.
- Drives ID-stage operand forward selects, the PC/IF-ID stall, branch-operand stalls, and the store-data forward.
- Sits beside the decoder in ID; consumes decoded fields, not raw instructions.

---
 rtl/hazard_scoreboard.sv | 83 ++++++++
 tb/tb_hazard_scoreboard.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard/forwarding control over a shift-register write scoreboard.
// Define HAZARD_STORE_FWD_EN to let a store take load data at MEM instead of stalling.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_is_store,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic              fwd_store_mem
);
  typedef logic [PIPE_DEPTH:1][REG_AW-1:0] addr_t;
  typedef logic [PIPE_DEPTH:1][SEL_W-1:0]  rdy_t;
  logic [PIPE_DEPTH:1] v_q;
  addr_t               a_q;
  rdy_t                r_q;
  logic [SEL_W:0]      res_a, res_b;
  logic                blk_a, blk_b, waive, ins;
  // Returns {blocked, stage} of the youngest matching entry; scanning oldest-first lets the youngest overwrite.
  function automatic logic [SEL_W:0] resolve(input logic en, input logic [REG_AW-1:0] x, input logic br,
                                             input logic [PIPE_DEPTH:1] v, input addr_t a, input rdy_t r);
    logic [SEL_W:0] res, need;
    res = '0;
    need = '0;
    for (int s = PIPE_DEPTH; s >= 1; s--)
      if (en && v[s] && a[s] == x) begin
        need = {1'b0, r[s]} + {{SEL_W{1'b0}}, br};
        res = {({1'b0, SEL_W'(s)} < need), SEL_W'(s)};
      end
    return res;
  endfunction
  always_comb begin
    res_a = resolve(id_valid & id_use_rs & (id_rs != '0), id_rs, id_is_branch, v_q, a_q, r_q);
    res_b = resolve(id_valid & id_use_rt & (id_rt != '0), id_rt, id_is_branch, v_q, a_q, r_q);
    blk_a = res_a[SEL_W];
    blk_b = res_b[SEL_W];
  end
`ifdef HAZARD_STORE_FWD_EN
  logic sf_q;
  // A single-cycle load in EX feeds the store's data straight from its MEM read one cycle later.
  assign waive = id_is_store & blk_b & (res_b[SEL_W-1:0] == SEL_W'(1))
               & (r_q[1] == SEL_W'(1 + LOAD_LAT)) & (LOAD_LAT == 1) & !blk_a;
  always_ff @(posedge clk)
    if (rst) sf_q <= 1'b0;
    else if (!hold) sf_q <= waive & !stall & !flush;
  assign fwd_store_mem = sf_q;
`else
  logic unused_store;
  assign unused_store  = id_is_store;
  assign waive         = 1'b0;
  assign fwd_store_mem = 1'b0;
`endif
  assign stall     = hold | blk_a | (blk_b & !waive);
  assign fwd_a_sel = blk_a ? '0 : res_a[SEL_W-1:0];
  assign fwd_b_sel = blk_b ? '0 : res_b[SEL_W-1:0];
  assign ins       = id_valid & id_wreg & (id_waddr != '0) & !stall & !flush;
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
      r_q <= '0;
    end else if (!hold) begin
      v_q <= {v_q[PIPE_DEPTH-1:1], ins};
      a_q <= {a_q[PIPE_DEPTH-1:1], id_waddr};
      r_q <= {r_q[PIPE_DEPTH-1:1], id_is_load ? SEL_W'(1 + LOAD_LAT) : SEL_W'(1)};
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, stalls, hold, reset and store forwarding.
module tb_hazard_scoreboard;
  logic       clk = 0, rst = 1;
  logic       id_valid, id_use_rs, id_use_rt, id_is_branch, id_is_store, id_wreg, id_is_load, flush, hold;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       stall, fsm, d_stall, d_fsm;
  logic [2:0] fa, fb, d_fa, d_fb;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_is_store(id_is_store), .id_wreg(id_wreg), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .flush(flush), .hold(hold), .stall(stall), .fwd_a_sel(fa), .fwd_b_sel(fb), .fwd_store_mem(fsm)
  );

  hazard_scoreboard #(.PIPE_DEPTH(4), .LOAD_LAT(2)) u_deep (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_is_store(id_is_store), .id_wreg(id_wreg), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .flush(flush), .hold(hold), .stall(d_stall), .fwd_a_sel(d_fa), .fwd_b_sel(d_fb), .fwd_store_mem(d_fsm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_valid, id_use_rs, id_use_rt, id_is_branch, id_is_store, id_wreg, id_is_load, flush, hold} = '0;
    id_rs = 0; id_rt = 0; id_waddr = 0;
  endtask

  task automatic op(input logic [4:0] rs, input logic [4:0] rt, input logic wr, input logic [4:0] wa,
                    input logic ld, input logic br, input logic st);
    idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = 1; id_use_rt = 1;
    id_wreg = wr; id_waddr = wa; id_is_load = ld; id_is_branch = br; id_is_store = st;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    op(5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa, fb, fsm} !== 8'h00) begin n_fail++;
      $display("FAIL reset: stall=%b fa=%0d fb=%0d fsm=%b, want all 0", stall, fa, fb, fsm); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    op(5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    op(5'd3, 5'd1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa, fb} !== {1'b0, 3'd1, 3'd0}) begin n_fail++;
      $display("FAIL alu_s1: stall=%b fa=%0d fb=%0d, want 0 1 0", stall, fa, fb); end
    do_reset();
    op(5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick(); idle(); tick();
    op(5'd1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa, fb} !== {1'b0, 3'd0, 3'd2}) begin n_fail++;
      $display("FAIL alu_s2: stall=%b fa=%0d fb=%0d, want 0 0 2", stall, fa, fb); end
  endtask

  task automatic test_load_use();
    do_reset();
    op(5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    op(5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL load_stall: stall=%b fa=%0d, want 1 0", stall, fa); end
    tick();
    n_chk++; if ({stall, fa} !== {1'b0, 3'd2}) begin n_fail++;
      $display("FAIL load_fwd: stall=%b fa=%0d, want 0 2", stall, fa); end
  endtask

  task automatic test_deep_load();
    do_reset();
    op(5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    op(5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({d_stall, d_fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL deep_stall1: stall=%b fa=%0d, want 1 0", d_stall, d_fa); end
    tick();
    n_chk++; if ({d_stall, d_fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL deep_stall2: stall=%b fa=%0d, want 1 0", d_stall, d_fa); end
    tick();
    n_chk++; if ({d_stall, d_fa} !== {1'b0, 3'd3}) begin n_fail++;
      $display("FAIL deep_fwd: stall=%b fa=%0d, want 0 3", d_stall, d_fa); end
  endtask

  task automatic test_branch();
    do_reset();
    op(5'd1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    op(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_chk++; if ({stall, fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL br_alu_stall: stall=%b fa=%0d, want 1 0", stall, fa); end
    tick();
    n_chk++; if ({stall, fa} !== {1'b0, 3'd2}) begin n_fail++;
      $display("FAIL br_alu_fwd: stall=%b fa=%0d, want 0 2", stall, fa); end
    do_reset();
    op(5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    op(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    n_chk++; if ({stall, fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL br_ld_stall1: stall=%b fa=%0d, want 1 0", stall, fa); end
    tick();
    n_chk++; if ({stall, fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL br_ld_stall2: stall=%b fa=%0d, want 1 0", stall, fa); end
    tick();
    n_chk++; if ({stall, fa} !== {1'b0, 3'd3}) begin n_fail++;
      $display("FAIL br_ld_fwd: stall=%b fa=%0d, want 0 3", stall, fa); end
  endtask

  task automatic test_youngest_zero_flush();
    do_reset();
    op(5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    op(5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    op(5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa, fb} !== {1'b0, 3'd1, 3'd1}) begin n_fail++;
      $display("FAIL youngest: stall=%b fa=%0d fb=%0d, want 0 1 1", stall, fa, fb); end
    do_reset();
    op(5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    op(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa, fb} !== 7'd0) begin n_fail++;
      $display("FAIL reg0: stall=%b fa=%0d fb=%0d, want 0 0 0", stall, fa, fb); end
    do_reset();
    op(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    flush = 1;
    tick();
    op(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa} !== 4'd0) begin n_fail++;
      $display("FAIL flush: stall=%b fa=%0d, want 0 0", stall, fa); end
  endtask

  task automatic test_store();
    do_reset();
    op(5'd7, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    op(5'd7, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_STORE_FWD_EN
    n_chk++; if ({stall, fb, fsm} !== {1'b0, 3'd0, 1'b0}) begin n_fail++;
      $display("FAIL st_waive: stall=%b fb=%0d fsm=%b, want 0 0 0", stall, fb, fsm); end
    tick(); idle(); #1;
    n_chk++; if (fsm !== 1'b1) begin n_fail++;
      $display("FAIL st_fsm_on: fsm=%b, want 1", fsm); end
    tick();
    n_chk++; if (fsm !== 1'b0) begin n_fail++;
      $display("FAIL st_fsm_off: fsm=%b, want 0", fsm); end
`else
    n_chk++; if ({stall, fb} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL st_stall: stall=%b fb=%0d, want 1 0", stall, fb); end
    tick();
    n_chk++; if ({stall, fb, fsm} !== {1'b0, 3'd2, 1'b0}) begin n_fail++;
      $display("FAIL st_fwd: stall=%b fb=%0d fsm=%b, want 0 2 0", stall, fb, fsm); end
`endif
  endtask

  task automatic test_hold_reset();
    do_reset();
    op(5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    op(5'd1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    hold = 1; #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (stall !== 1'b1) begin n_fail++;
        $display("FAIL hold_stall[%0d]: stall=%b, want 1", i, stall); end
      tick();
    end
    op(5'd2, 5'd1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    n_chk++; if ({stall, fa} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL hold_kept_s1: stall=%b fa=%0d, want 1 0", stall, fa); end
    rst = 1;
    tick();
    rst = 0; #1;
    n_chk++; if ({stall, fa, fb} !== 7'd0) begin n_fail++;
      $display("FAIL rst_mid_stall: stall=%b fa=%0d fb=%0d, want 0 0 0", stall, fa, fb); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_deep_load();
    test_branch();
    test_youngest_zero_flush();
    test_store();
    test_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
